// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache.
// Stats counters are built only when CACHE_STATS_EN is defined.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESP
  } state_e;

  localparam int CNT_W = 16;

  function automatic int tag_bits(input int aw, input int ib);
    return aw - ib;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for one-word lines.
// Async read, sync write, cleared by rst_n.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic                  wr_en_i,
  input  logic [tag_bits(ADDR_WIDTH, INDEX_BITS)-1:0] wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  valid_o,
  output logic [tag_bits(ADDR_WIDTH, INDEX_BITS)-1:0] tag_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int TW    = tag_bits(ADDR_WIDTH, INDEX_BITS);
  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TW-1:0]         tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      valid_q[idx_i] <= 1'b1;
      tag_q[idx_i]   <= wr_tag_i;
      data_q[idx_i]  <= wr_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped write-through no-write-allocate cache FSM and RAM port.
// Optional hit/miss counters under CACHE_STATS_EN.
module cache_responder
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int TW = tag_bits(ADDR_WIDTH, INDEX_BITS);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TW-1:0]         tag;
  logic                  ls_valid;
  logic [TW-1:0]         ls_tag;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_we;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  hit;

  assign idx = addr_q[INDEX_BITS-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:INDEX_BITS];
  assign hit = ls_valid && (ls_tag == tag);

  cache_line_store #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx_i    (idx),
    .wr_en_i  (ls_we),
    .wr_tag_i (tag),
    .wr_data_i(ls_wdata),
    .valid_o  (ls_valid),
    .tag_o    (ls_tag),
    .data_o   (ls_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    ls_we    = 1'b0;
    ls_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cnt_d = '0;
        if (we_q) begin
          // write hit refreshes the line; a miss leaves it untouched
          ls_we   = hit;
          state_d = WRITE;
        end else if (hit) begin
          rdata_d = ls_rdata;
          state_d = RESP;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (cnt_q == LAST) begin
          ls_we    = 1'b1;
          ls_wdata = mem_rdata;
          rdata_d  = mem_rdata;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = (state_q == RESP);
  assign cpu_busy  = (state_q != IDLE);
  assign mem_oe    = (state_q == FILL);
  assign mem_we    = (state_q == WRITE);
  assign mem_cs    = mem_oe || mem_we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_q, miss_q;
  logic             look;

  assign look = (state_q == LOOKUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (look && hit && (hit_q != '1))
        hit_q <= hit_q + 1'b1;
      if (look && !hit && (miss_q != '1))
        miss_q <= miss_q + 1'b1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/cache_responder.md
Name: cache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller that answers CPU fetch/load/store requests.
- Sits between the CPU datapath (MAR/MBR side) and single_port_sync_ram_large.
- On a hit, it serves the request from internal lines. On a miss, it drives the RAM's cs/we/oe/addr interface and fills the line.
- It replaces the testbench-level tristate found/oe muxing with a clean request/ready handshake.

Parameters:
- ADDR_WIDTH, 28, word address width shared with RAM.
- DATA_WIDTH, 32, data word width.
- INDEX_BITS, 4, line index width; 2**INDEX_BITS one-word lines.
- MEM_LATENCY, 1, cycles from mem_oe assertion to valid mem_rdata (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load/fetch.
- cpu_addr  in  ADDR_WIDTH  request word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high from accept through the cycle cpu_ready pulses.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable (read).
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- hit_count  out  16  hit counter (see Optional Feature).
- miss_count  out  16  miss counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and all valid bits clear.
  - cpu_ready, cpu_busy, mem_cs, mem_we, mem_oe are 0; cpu_rdata, mem_addr, mem_wdata are 0; counters are 0.
  - Reset mid-transaction abandons it; no ready is issued and mem strobes drop immediately.
- Address split: index = addr[INDEX_BITS-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_BITS].
- Accept: in IDLE, cpu_req=1 at a rising edge latches addr/we/wdata. State goes to LOOKUP and cpu_busy=1. cpu_req is ignored while busy.
- LOOKUP (1 cycle): hit = valid[index] && tag match.
  - Read hit -> RESP with cpu_rdata = line data. cpu_ready pulses 2 cycles after the accept edge.
  - Read miss -> FILL.
  - Write (hit or miss) -> WRITE. On a hit, the line data updates in this cycle.
- FILL:
  - mem_cs=1, mem_oe=1, mem_we=0, mem_addr = latched addr, held for MEM_LATENCY cycles.
  - On the final cycle, capture mem_rdata into the line, set valid and tag, load cpu_rdata, then go to RESP.
  - Read-miss cpu_ready arrives MEM_LATENCY+2 cycles after accept.
- WRITE:
  - Exactly 1 cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_addr/mem_wdata = latched values, then RESP.
  - A write miss does not allocate.
  - Write cpu_ready arrives 3 cycles after accept.
- RESP (1 cycle): cpu_ready=1 and all mem strobes are 0. Next state is IDLE, where cpu_busy drops.
  - cpu_req high in the IDLE cycle after RESP is accepted normally; back-to-back throughput is one request per latency+1 cycles.
- cpu_rdata holds its last value until the next read completes. It is don't-care for writes but must not be X.
- mem_cs/we/oe are never asserted outside FILL/WRITE. mem_we and mem_oe are mutually exclusive.
- Aliasing: same index with a different tag evicts on a read fill; no writeback is needed (write-through).

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: hit_count and miss_count each increment by 1 in the LOOKUP cycle (reads and writes both counted) and saturate at 16'hFFFF.
- Undefined: no counter registers are built and both outputs are tied to 0.

Decomposition:
- Package cache_pkg holds:
  - the state enum {IDLE, LOOKUP, FILL, WRITE, RESP};
  - localparam TAG_BITS = ADDR_WIDTH-INDEX_BITS, exposed as a function taking the parameters;
  - the counter width constant, 16.
- Sub-module cache_line_store holds the valid/tag/data arrays: async read, sync write, clear on rst_n. The FSM and mem interface stay in cache_responder.

Test Plan:
- Cold read miss: preload RAM[0x100]=0x1000011E, cpu_req load 0x100 -> mem_oe high for MEM_LATENCY cycles at addr 0x100. cpu_ready arrives MEM_LATENCY+2 cycles after accept with cpu_rdata=0x1000011E; miss_count=1.
- Read hit: repeat load 0x100 -> no mem_cs activity, cpu_ready 2 cycles after accept, rdata=0x1000011E, hit_count=1.
- Write-through hit: store 0x100 with 0xB8000001 -> one mem_we cycle (addr 0x100, wdata 0xB8000001). A subsequent load 0x100 hits and returns 0xB8000001.
- Write miss no-allocate: store 0x11A with 0x7800000A -> RAM written. The next load 0x11A misses, fills, and returns 0x7800000A.
- Conflict eviction (INDEX_BITS=4): load 0x104, then load 0x114 (same index 4), then load 0x104 -> three misses; every response returns the correct RAM word.
- Reset mid-FILL: set MEM_LATENCY=3, deassert rst_n during the second FILL cycle -> mem_cs/oe go to 0 at once, no cpu_ready, all lines invalid. A later load 0x100 misses.
